// File: rtl/ls_pkg.sv
// ls_pkg -- shared definitions for the load/store stage.
//   state_e     : load/store FSM states
//   MASK_B/H/W  : access-size byte masks (byte, half, word)
//   lane_extend : masks a right-aligned load word to the access size and
//                 zero- or sign-extends it to 32 bits
package ls_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  function automatic logic [31:0] lane_extend(input logic [31:0] word,
                                              input logic [3:0]  mask,
                                              input logic        sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = word[7:0];
    h = word[15:0];
    case (mask)
      MASK_B:  r = sgn ? 32'(b) : {24'd0, word[7:0]};
      MASK_H:  r = sgn ? 32'(h) : {16'd0, word[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ls_align.sv
// ls_align -- combinational load alignment and extension.
// Shifts the addressed byte lane of the raw memory word down to bit 0, then
// masks it to the access size and zero/sign-extends it.
//   rdata     : raw load word from memory
//   offset    : byte offset inside the word (address bits [1:0])
//   mask      : access-size byte mask
//   is_signed : sign-extend when set
//   data      : aligned, extended load result
module ls_align
  import ls_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int MASK_W = 4
) (
  input  logic [XLEN-1:0]   rdata,
  input  logic [1:0]        offset,
  input  logic [MASK_W-1:0] mask,
  input  logic              is_signed,
  output logic [XLEN-1:0]   data
);

  logic [XLEN-1:0]    shifted;
  logic signed [31:0] ext;

  assign shifted = rdata >> {offset, 3'b000};
  assign ext     = lane_extend(shifted[31:0], 4'(mask), is_signed);
  assign data    = XLEN'(ext);

endmodule

// File: rtl/ls_unit.sv
// ls_unit -- load/store pipeline stage (consumer of the EX->LS register).
// Accepts one m_* bundle at a time (M_valid_i/m_ready_o), issues at most one
// data-memory transaction for loads/stores, and presents a registered
// write-back bundle to the LS->WB register (w_valid_o/w_ready_i).
// Ports:
//   clk_i, rst_i (async, active-low)
//   m_*           : incoming bundle from EX
//   mem_req_*     : request channel (addr word-aligned, wdata/wstrb lane-shifted)
//   mem_rvalid_i/mem_rdata_i : response channel (load data or store ack)
//   w_*           : write-back bundle
// Optional: define LS_MISALIGN_CHECK_EN to add w_misalign_o and to turn
// misaligned half/word accesses into memory-free pass-throughs; otherwise
// the strobe is simply truncated to the word.
module ls_unit
  import ls_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int SYS_W  = 8,
  parameter int RS_W   = 5,
  parameter int MASK_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [SYS_W-1:0]  m_sys_info_i,
  input  logic              m_wenReg_i,
  input  logic              m_wenCsr_i,
  input  logic [RS_W-1:0]   m_rd_i,
  input  logic [XLEN-1:0]   m_src1_i,
  input  logic [XLEN-1:0]   m_imm_i,
  input  logic              m_is_load_signed_i,
  input  logic              m_wenMem_i,
  input  logic              m_renMem_i,
  input  logic [MASK_W-1:0] m_mask_i,
  input  logic [XLEN-1:0]   m_npc_i,
  input  logic [XLEN-1:0]   m_res_i,
  input  logic              m_cnd_i,
  input  logic              M_valid_i,
  output logic              m_ready_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic              mem_wen_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [3:0]        mem_wstrb_o,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              w_valid_o,
  input  logic              w_ready_i,
  output logic [SYS_W-1:0]  w_sys_info_o,
  output logic              w_wenReg_o,
  output logic              w_wenCsr_o,
  output logic [RS_W-1:0]   w_rd_o,
  output logic [XLEN-1:0]   w_imm_o,
  output logic [XLEN-1:0]   w_npc_o,
  output logic              w_cnd_o,
`ifdef LS_MISALIGN_CHECK_EN
  output logic              w_misalign_o,
`endif
  output logic [XLEN-1:0]   w_data_o
);

  state_e state_q, state_d;

  logic [XLEN-1:0]   src1_q;
  logic [XLEN-1:0]   res_q;
  logic [MASK_W-1:0] mask_q;
  logic              signed_q;
  logic              is_store_q;
  logic              is_load_q;

  logic              accept;
  logic              capture;
  logic              mem_op;
  logic              misalign_in;
  logic [XLEN-1:0]   load_data;

  assign mem_op = m_wenMem_i | m_renMem_i;

`ifdef LS_MISALIGN_CHECK_EN
  assign misalign_in = mem_op &
                       (((m_mask_i == MASK_W'(ls_pkg::MASK_H)) & m_res_i[0]) |
                        ((m_mask_i == MASK_W'(ls_pkg::MASK_W)) & (m_res_i[1:0] != 2'b00)));
`else
  assign misalign_in = 1'b0;
`endif

  assign accept  = M_valid_i & (state_q == ST_IDLE);
  // A response is only meaningful once the request has been (or is being)
  // accepted; in IDLE/OUT it is dropped.
  assign capture = mem_rvalid_i &
                   (((state_q == ST_REQ) & mem_req_ready_i) | (state_q == ST_WAIT));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    m_ready_o       = 1'b0;
    mem_req_valid_o = 1'b0;
    w_valid_o       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Gated by rst_i so the upstream sees no acceptance while reset is held.
        m_ready_o = rst_i;
        if (M_valid_i) state_d = (mem_op & ~misalign_in) ? ST_REQ : ST_OUT;
      end
      ST_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_d = mem_rvalid_i ? ST_OUT : ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rvalid_i) state_d = ST_OUT;
      end
      ST_OUT: begin
        w_valid_o = 1'b1;
        if (w_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  ls_align #(
    .XLEN   (XLEN),
    .MASK_W (MASK_W)
  ) u_align (
    .rdata     (mem_rdata_i),
    .offset    (res_q[1:0]),
    .mask      (mask_q),
    .is_signed (signed_q),
    .data      (load_data)
  );

  // Bundle capture on accept; w_data_o is preset to res so non-loads need
  // no further update, and loads overwrite it with the aligned response.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      w_sys_info_o <= '0;
      w_wenReg_o   <= 1'b0;
      w_wenCsr_o   <= 1'b0;
      w_rd_o       <= '0;
      w_imm_o      <= '0;
      w_npc_o      <= '0;
      w_cnd_o      <= 1'b0;
      w_data_o     <= '0;
      src1_q       <= '0;
      res_q        <= '0;
      mask_q       <= '0;
      signed_q     <= 1'b0;
      is_store_q   <= 1'b0;
      is_load_q    <= 1'b0;
`ifdef LS_MISALIGN_CHECK_EN
      w_misalign_o <= 1'b0;
`endif
    end else if (accept) begin
      w_sys_info_o <= m_sys_info_i;
      w_wenReg_o   <= m_wenReg_i & ~misalign_in;
      w_wenCsr_o   <= m_wenCsr_i;
      w_rd_o       <= m_rd_i;
      w_imm_o      <= m_imm_i;
      w_npc_o      <= m_npc_i;
      w_cnd_o      <= m_cnd_i;
      w_data_o     <= m_res_i;
      src1_q       <= m_src1_i;
      res_q        <= m_res_i;
      mask_q       <= m_mask_i;
      signed_q     <= m_is_load_signed_i;
      // Store wins when both memory enables are set.
      is_store_q   <= m_wenMem_i;
      is_load_q    <= m_renMem_i & ~m_wenMem_i;
`ifdef LS_MISALIGN_CHECK_EN
      w_misalign_o <= misalign_in;
`endif
    end else if (capture) begin
      w_data_o <= is_load_q ? load_data : res_q;
    end
  end

  assign mem_addr_o  = {res_q[XLEN-1:2], 2'b00};
  assign mem_wen_o   = is_store_q;
  assign mem_wdata_o = src1_q << {res_q[1:0], 3'b000};
  // Unaligned accesses lose the lanes shifted past byte 3 (no split access).
  assign mem_wstrb_o = 4'(mask_q) << res_q[1:0];

endmodule

// File: doc/ls_unit.md
Name: ls_unit

Overview:
- Load/store stage. It is the consumer end of the EX→LS pipeline register: it takes the registered `m_*` bundle under the `M_valid`/`m_ready` handshake.
- It issues at most one data-memory transaction per instruction, aligns and extends load data, and presents a write-back bundle to the LS→WB register.
- Non-memory instructions pass through in one cycle.

Parameters:
- XLEN, 32, data/address width
- SYS_W, 8, width of opaque sys_info bundle
- RS_W, 5, register index width
- MASK_W, 4, access-size byte mask (0001 byte, 0011 half, 1111 word)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-low
- m_sys_info_i  in  SYS_W  passed through to WB
- m_wenReg_i  in  1  GPR write enable
- m_wenCsr_i  in  1  CSR write enable
- m_rd_i  in  RS_W  destination register
- m_src1_i  in  XLEN  store data (rs2 value)
- m_imm_i  in  XLEN  passed through (CSR use)
- m_is_load_signed_i  in  1  sign-extend load
- m_wenMem_i  in  1  store
- m_renMem_i  in  1  load
- m_mask_i  in  MASK_W  access size
- m_npc_i  in  XLEN  next pc, passed through
- m_res_i  in  XLEN  ALU result; effective address for load/store
- m_cnd_i  in  1  branch condition, passed through
- M_valid_i  in  1  upstream bundle valid
- m_ready_o  out  1  upstream accept
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_addr_o  out  XLEN  word-aligned address (`res & ~3`)
- mem_wen_o  out  1  1 = store
- mem_wdata_o  out  XLEN  store data shifted to byte lane
- mem_wstrb_o  out  4  byte strobes (mask << `res[1:0]`)
- mem_rvalid_i  in  1  response valid (load data or store ack)
- mem_rdata_i  in  XLEN  raw load word
- w_valid_o  out  1  WB bundle valid
- w_ready_i  in  1  WB accepts
- w_sys_info_o, w_wenReg_o, w_wenCsr_o, w_rd_o, w_imm_o, w_npc_o, w_cnd_o  out  as inputs  registered pass-through
- w_data_o  out  XLEN  load result, or `m_res_i` for non-load

Behaviour:
- FSM states: IDLE, REQ, WAIT, OUT.
- Reset (rst_i=0, async): state=IDLE, all outputs 0, m_ready_o=0 during reset.

IDLE:
- m_ready_o=1.
- On M_valid_i & m_ready_o, latch the whole bundle.
- If wenMem|renMem: go to REQ.
- Otherwise: w_data=res, go to OUT. Latency 1 cycle.

REQ:
- mem_req_valid_o=1; address, wdata, wstrb held stable until accepted.
- On mem_req_ready_i: go to WAIT.
- If mem_rvalid_i arrives in the same cycle as the accept, go directly to OUT, capturing the response.

WAIT:
- m_ready_o=0.
- On mem_rvalid_i, the load result is the selected lane, `rdata >> (8*res[1:0])`, masked to size and then zero- or sign-extended per is_load_signed.
- Stores write w_data=res. Go to OUT.

OUT:
- w_valid_o=1; bundle held stable while w_ready_i=0.
- On w_ready_i: go to IDLE.
- m_ready_o=0 in OUT; no skid buffer.
- Throughput: 1 instruction / 2 cycles for ALU ops; 3+ cycles for memory ops.

Rules:
- Both wenMem and renMem set: treat as store.
- mem_rvalid_i while not in REQ/WAIT is ignored.
- Unaligned half/word access: the strobe is truncated to 4 bits; upper bytes are dropped (no split access).
- mem_req_valid_o never deasserts before mem_req_ready_i.
- Reset mid-transaction: return to IDLE; any outstanding response is discarded.

Optional Feature:
- Macro LS_MISALIGN_CHECK_EN.
- When defined:
  - Adds output `w_misalign_o`.
  - A half access with res[0]=1, or a word access with res[1:0]≠0, skips REQ. It goes straight to OUT with w_misalign_o=1, w_wenReg_o=0, w_data_o=res.
- When undefined:
  - No port.
  - Truncation behaviour as above.

Decomposition:
- Shared package ls_pkg:
  - FSM state enum
  - mask encodings MASK_B/H/W
  - helper function for byte-lane extract/extend
- Sub-module ls_align: combinational load alignment and extension (rdata, offset, mask, signed → XLEN). It is reused by any future cache path.

Test Plan:
- ALU op: res=0x1234, renMem=wenMem=0 → w_valid_o next cycle, w_data_o=0x1234, no mem_req_valid_o.
- Signed byte load: res=0x103, mask=0001, signed=1, rdata=0x80FF_FF00 → w_data_o=0xFFFF_FF80.
- Unsigned half load: res=0x102, mask=0011, rdata=0xBEEF_1234 → w_data_o=0x0000_BEEF.
- Store word: res=0x200, src1=0xDEADBEEF, mem_req_ready_i low 3 cycles → addr/wdata/wstrb=0xF stable throughout; w_valid_o only after mem_rvalid_i.
- Backpressure: w_ready_i=0 for 4 cycles in OUT → outputs held, m_ready_o=0; release → IDLE, accepts next bundle.
- rst_i pulled low in WAIT → all outputs 0 asynchronously; a later mem_rvalid_i produces no w_valid_o.
